// File: rtl/fetch_queue_if.sv
// Fetch queue bus: redirect input, instruction memory request/response
// channel and the registered decode-stage outputs.
interface fetch_queue_if;
  logic [31:0] wb_reg_pc;
  logic        wb_branch_hazard;
  logic        mem_start;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_data;
  logic        mem_data_valid;
  logic        stall_flg;
  logic [31:0] id_reg_pc;
  logic [31:0] id_inst;

  // Fetch queue side
  modport master (
    input  wb_reg_pc, wb_branch_hazard, mem_ready, mem_data, mem_data_valid, stall_flg,
    output mem_start, mem_addr, id_reg_pc, id_inst
  );

  // Pipeline / memory side
  modport slave (
    output wb_reg_pc, wb_branch_hazard, mem_ready, mem_data, mem_data_valid, stall_flg,
    input  mem_start, mem_addr, id_reg_pc, id_inst
  );
endinterface

// File: rtl/fetch_queue.sv
// Instruction fetch queue: issues in-order memory requests, tags responses
// with their request PC, buffers them while decode stalls and discards
// responses that belong to requests issued before a redirect.
module fetch_queue #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          QDEPTH    = 4,
  parameter int          MAX_OUT   = 2,
  parameter logic [31:0] REGPC_NOP = 32'hFFFF_FFFF,
  parameter logic [31:0] INST_NOP  = 32'h0000_0013
) (
  input logic           clk,
  input logic           rst_n,
  fetch_queue_if.master bus
);
  localparam int            QW        = $clog2(QDEPTH);
  localparam int            AW        = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  // Wide enough to hold count + live (at most 2*QDEPTH) without overflow.
  localparam int            CW        = $clog2(QDEPTH + 1) + 1;
  localparam logic [CW-1:0] QDEPTH_C  = CW'(QDEPTH);
  localparam logic [CW-1:0] MAX_OUT_C = CW'(MAX_OUT);
  localparam logic [AW-1:0] SLOT_LAST = AW'(MAX_OUT - 1);

  logic [31:0]   fetch_pc_r;
  logic [CW-1:0] count_r;
  logic [CW-1:0] out_cnt_r;
  logic [CW-1:0] drop_cnt_r;
  logic [QW-1:0] head_r;
  logic [QW-1:0] tail_r;
  logic [AW-1:0] opush_r;
  logic [AW-1:0] opop_r;
  logic [31:0]   q_pc_r   [QDEPTH];
  logic [31:0]   q_inst_r [QDEPTH];
  logic [31:0]   opc_r    [MAX_OUT];
  logic [31:0]   id_reg_pc_r;
  logic [31:0]   id_inst_r;

  logic [CW-1:0] live_s;
  logic          room_s;
  logic          mem_start_s;
  logic [31:0]   mem_addr_s;
  logic          accept_s;
  logic          resp_s;
  logic          live_resp_s;
  logic          pop_s;
  logic          push_s;
  logic          bypass_s;

  // Advance a pointer over the MAX_OUT outstanding-address slots.
  function automatic logic [AW-1:0] slot_next(input logic [AW-1:0] p);
    if (p == SLOT_LAST) begin
      slot_next = {AW{1'b0}};
    end else begin
      slot_next = p + AW'(1'b1);
    end
  endfunction

  // Issue decision, response classification and queue push/pop strobes.
  always_comb begin
    live_s = out_cnt_r - drop_cnt_r;
    if (bus.wb_branch_hazard) begin
      // Everything buffered or in flight is about to be discarded.
      room_s     = 1'b1;
      mem_addr_s = bus.wb_reg_pc;
    end else begin
      room_s     = (count_r + live_s) < QDEPTH_C;
      mem_addr_s = fetch_pc_r;
    end
    mem_start_s = rst_n && (out_cnt_r < MAX_OUT_C) && room_s;
    accept_s    = mem_start_s && bus.mem_ready;
    // A strobe with nothing outstanding is a protocol error and is ignored.
    resp_s      = bus.mem_data_valid && (out_cnt_r != {CW{1'b0}});
    live_resp_s = resp_s && (drop_cnt_r == {CW{1'b0}});
    pop_s       = !bus.wb_branch_hazard && !bus.stall_flg && (count_r != {CW{1'b0}});
    push_s      = !bus.wb_branch_hazard && live_resp_s &&
                  (bus.stall_flg || (count_r != {CW{1'b0}}));
    bypass_s    = !bus.wb_branch_hazard && !bus.stall_flg &&
                  (count_r == {CW{1'b0}}) && live_resp_s;
  end

  // Control state: fetch PC, counters, pointers and decode-stage registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_r  <= RESET_PC;
      count_r     <= {CW{1'b0}};
      out_cnt_r   <= {CW{1'b0}};
      drop_cnt_r  <= {CW{1'b0}};
      head_r      <= {QW{1'b0}};
      tail_r      <= {QW{1'b0}};
      opush_r     <= {AW{1'b0}};
      opop_r      <= {AW{1'b0}};
      id_reg_pc_r <= REGPC_NOP;
      id_inst_r   <= INST_NOP;
    end else begin
      out_cnt_r <= out_cnt_r + {{(CW-1){1'b0}}, accept_s} - {{(CW-1){1'b0}}, resp_s};
      if (accept_s) begin
        opush_r <= slot_next(opush_r);
      end
      if (resp_s) begin
        opop_r <= slot_next(opop_r);
      end
      if (bus.wb_branch_hazard) begin
        // Redirect: flush the queue; every older request becomes a drop.
        fetch_pc_r  <= bus.wb_reg_pc + (accept_s ? 32'd4 : 32'd0);
        drop_cnt_r  <= out_cnt_r - {{(CW-1){1'b0}}, resp_s};
        count_r     <= {CW{1'b0}};
        head_r      <= {QW{1'b0}};
        tail_r      <= {QW{1'b0}};
        id_reg_pc_r <= REGPC_NOP;
        id_inst_r   <= INST_NOP;
      end else begin
        if (accept_s) begin
          fetch_pc_r <= fetch_pc_r + 32'd4;
        end
        if (resp_s && (drop_cnt_r != {CW{1'b0}})) begin
          drop_cnt_r <= drop_cnt_r - {{(CW-1){1'b0}}, 1'b1};
        end
        count_r <= count_r + {{(CW-1){1'b0}}, push_s} - {{(CW-1){1'b0}}, pop_s};
        if (push_s) begin
          tail_r <= tail_r + QW'(1'b1);
        end
        if (pop_s) begin
          head_r      <= head_r + QW'(1'b1);
          id_reg_pc_r <= q_pc_r[head_r];
          id_inst_r   <= q_inst_r[head_r];
        end else if (bypass_s) begin
          id_reg_pc_r <= opc_r[opop_r];
          id_inst_r   <= bus.mem_data;
        end else begin
          id_reg_pc_r <= REGPC_NOP;
          id_inst_r   <= INST_NOP;
        end
      end
    end
  end

  // Storage: outstanding request addresses and buffered (pc, inst) entries.
  always_ff @(posedge clk) begin
    if (accept_s) begin
      opc_r[opush_r] <= mem_addr_s;
    end
    if (push_s) begin
      q_pc_r[tail_r]   <= opc_r[opop_r];
      q_inst_r[tail_r] <= bus.mem_data;
    end
  end

  assign bus.mem_start = mem_start_s;
  assign bus.mem_addr  = mem_addr_s;
  assign bus.id_reg_pc = id_reg_pc_r;
  assign bus.id_inst   = id_inst_r;
endmodule
